// File: rtl/debounce_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_n_pkg
// Description : Sizing helpers shared by the debouncer top and its per-bit
//               slice.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_n_pkg;

    // Per-bit counter wide enough to hold 0..STABLE_COUNT.
    function automatic int cnt_width(input int stable_count);
        return $clog2(stable_count + 1);
    endfunction

    // Prescaler width, never narrower than one bit.
    function automatic int pre_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : debounce_bit
// Description : One debounced bit: stability counter, accepted level and
//               registered rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
    import debounce_n_pkg::*;
#(
    parameter int STABLE_COUNT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sample,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_accept
);

    localparam int                 c_cnt_w    = cnt_width(STABLE_COUNT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_COUNT - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               r_level;
    logic               r_rise;
    logic               r_fall;
    logic               w_mismatch;
    logic               w_accept;

    assign w_mismatch = (i_d != r_level);
    // Acceptance strobe lets the top register o_change alongside the pulses.
    assign w_accept   = i_sample & w_mismatch & (r_cnt == c_cnt_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_sample) begin
                if (!w_mismatch) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_level <= i_d;
                    r_cnt   <= '0;
                    r_rise  <= i_d;
                    r_fall  <= ~i_d;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
        end
    end

    assign o_level  = r_level;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_accept = w_accept;

endmodule
`default_nettype wire

// File: rtl/debounce_n.sv
`default_nettype none
// ============================================================================
// Module      : debounce_n
// Description : Multi-bit debouncer and edge detector with a shared sample
//               prescaler, fed from an already-synchronized bus.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_n
    import debounce_n_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int STABLE_COUNT = 4,
    parameter int PRESCALE     = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_change
);

    localparam int                 c_pre_w    = pre_width(PRESCALE);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(PRESCALE - 1);

    logic [c_pre_w-1:0] r_pre;
    logic               r_change;
    logic               w_tick;
    logic               w_sample;
    logic [WIDTH-1:0]   w_level;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;
    logic [WIDTH-1:0]   w_accept;

    assign w_tick   = (r_pre == c_pre_last);
    assign w_sample = i_en & w_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pre <= '0;
        end else if (i_en) begin
            r_pre <= w_tick ? '0 : r_pre + c_pre_w'(1);
        end
    end

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_bit
            debounce_bit #(
                .STABLE_COUNT (STABLE_COUNT)
            ) u_bit (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_sample (w_sample),
                .i_d      (i_d[g]),
                .o_level  (w_level[g]),
                .o_rise   (w_rise[g]),
                .o_fall   (w_fall[g]),
                .o_accept (w_accept[g])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_change <= 1'b0;
        end else begin
            r_change <= |w_accept;
        end
    end

    assign o_level  = w_level;
    assign o_rise   = w_rise;
    assign o_fall   = w_fall;
    assign o_change = r_change;

endmodule
`default_nettype wire

// File: tb/tb_debounce_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_n
// Description : Self-checking bench for debounce_n, two configurations driven
//               in parallel against a sliding-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_n;

    logic       clk;
    logic       i_rst;
    logic       i_en;
    logic [3:0] i_d;

    logic [3:0] oa_level, oa_rise, oa_fall;
    logic       oa_change;
    logic [3:0] ob_level, ob_rise, ob_fall;
    logic       ob_change;

    int checks = 0;
    int errors = 0;

    debounce_n #(.WIDTH(4), .STABLE_COUNT(4), .PRESCALE(1)) u_dut_a (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_d      (i_d),
        .o_level  (oa_level),
        .o_rise   (oa_rise),
        .o_fall   (oa_fall),
        .o_change (oa_change)
    );

    debounce_n #(.WIDTH(4), .STABLE_COUNT(2), .PRESCALE(3)) u_dut_b (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_d      (i_d),
        .o_level  (ob_level),
        .o_rise   (ob_rise),
        .o_fall   (ob_fall),
        .o_change (ob_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a bit is accepted when its last STABLE_COUNT tick samples
    // (since reset or the previous acceptance) all differ from the level.
    logic [3:0] m_level  [2];
    logic [3:0] m_rise   [2];
    logic [3:0] m_fall   [2];
    logic       m_change [2];
    int         m_en_cnt [2];
    logic       hist     [2][4][4];
    int         hn       [2][4];

    function automatic int sc_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic int ps_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic model_update(input int k);
        bit tick;
        bit all_diff;
        if (i_rst) begin
            m_level[k] = '0; m_rise[k] = '0; m_fall[k] = '0; m_change[k] = 1'b0;
            m_en_cnt[k] = 0;
            for (int b = 0; b < 4; b++) hn[k][b] = 0;
        end else begin
            m_rise[k] = '0;
            m_fall[k] = '0;
            if (i_en) begin
                tick = ((m_en_cnt[k] % ps_of(k)) == ps_of(k) - 1);
                m_en_cnt[k]++;
                if (tick) begin
                    for (int b = 0; b < 4; b++) begin
                        for (int j = 3; j > 0; j--) hist[k][b][j] = hist[k][b][j-1];
                        hist[k][b][0] = i_d[b];
                        if (hn[k][b] < 4) hn[k][b]++;
                        if (hn[k][b] >= sc_of(k)) begin
                            all_diff = 1'b1;
                            for (int j = 0; j < sc_of(k); j++)
                                if (hist[k][b][j] == m_level[k][b]) all_diff = 1'b0;
                            if (all_diff) begin
                                m_level[k][b] = i_d[b];
                                if (i_d[b]) m_rise[k][b] = 1'b1;
                                else        m_fall[k][b] = 1'b1;
                                hn[k][b] = 0;
                            end
                        end
                    end
                end
            end
            m_change[k] = |(m_rise[k] | m_fall[k]);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk4("a_level",  oa_level,  m_level[0]);
        chk4("a_rise",   oa_rise,   m_rise[0]);
        chk4("a_fall",   oa_fall,   m_fall[0]);
        chk4("a_change", {3'b0, oa_change}, {3'b0, m_change[0]});
        chk4("b_level",  ob_level,  m_level[1]);
        chk4("b_rise",   ob_rise,   m_rise[1]);
        chk4("b_fall",   ob_fall,   m_fall[1]);
        chk4("b_change", {3'b0, ob_change}, {3'b0, m_change[1]});
    endtask

    task automatic step(input logic rst, input logic en, input logic [3:0] d);
        i_rst = rst;
        i_en  = en;
        i_d   = d;
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_model();
    endtask

    initial begin
        int n;
        logic [3:0] rd;
        i_rst = 1'b1; i_en = 1'b1; i_d = 4'hF;

        // Reset with input high, then acceptance on the 4th edge after release
        step(1'b1, 1'b1, 4'hF);
        step(1'b1, 1'b1, 4'hF);
        chk4("rst_level", oa_level, 4'h0);
        chk4("rst_rise",  oa_rise,  4'h0);
        chk4("rst_chg",   {3'b0, oa_change}, 4'h0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 4'hF);
            if (i < 4) chk4("pre_accept_level", oa_level, 4'h0);
        end
        chk4("accept_level", oa_level, 4'hF);
        chk4("accept_rise",  oa_rise,  4'hF);
        chk4("accept_chg",   {3'b0, oa_change}, 4'h1);
        step(1'b0, 1'b1, 4'hF);
        chk4("rise_one_cycle", oa_rise, 4'h0);
        chk4("chg_one_cycle",  {3'b0, oa_change}, 4'h0);

        // Fall on bit 0
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 4'hE);
        chk4("fall_level", oa_level, 4'hE);
        chk4("fall_pulse", oa_fall,  4'h1);
        chk4("fall_rise",  oa_rise,  4'h0);

        // Glitch of 3 samples on bit 0 never reaches the level
        step(1'b1, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, (i < 3) ? 4'h1 : 4'h0);
            chk4("glitch_level", oa_level, 4'h0);
            chk4("glitch_chg",   {3'b0, oa_change}, 4'h0);
        end

        // Prescaled instance: bit 2 step, latency between 4 and 6 edges
        step(1'b1, 1'b1, 4'h0);
        n = 0;
        do begin
            step(1'b0, 1'b1, 4'h4);
            n++;
        end while (ob_level[2] !== 1'b1 && n < 12);
        chkn("ps_latency_in_range", (n >= 4 && n <= 6) ? 1 : 0, 1);
        chk4("ps_rise", ob_rise, 4'h4);

        // Enable hold: two mismatching ticks, five disabled cycles
        step(1'b1, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'h1);
        step(1'b0, 1'b1, 4'h1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'h1);
            chk4("en_hold_level", oa_level, 4'h0);
        end
        n = 0;
        do begin
            step(1'b0, 1'b1, 4'h1);
            n++;
        end while (oa_level[0] !== 1'b1 && n < 12);
        chkn("en_restore_latency", n, 2);

        // Reset after 3 of 4 mismatching ticks discards progress
        step(1'b1, 1'b1, 4'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'hF);
        step(1'b1, 1'b1, 4'hF);
        n = 0;
        do begin
            step(1'b0, 1'b1, 4'hF);
            n++;
        end while (oa_level !== 4'hF && n < 12);
        chkn("rst_mid_latency", n, 4);

        // Randomized run against the model
        rd = 4'h0;
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3, 0) == 0) rd[b] = ~rd[b];
            step(($urandom_range(63, 0) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(4, 0) != 0) ? 1'b1 : 1'b0,
                 rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
